// File: rtl/pipe_mem.sv
// -----------------------------------------------------------------------------
// pipe_mem : MEM stage plus MEM/WB pipeline register.
//
// Issues loads/stores to data memory over a req/ack handshake. The data memory
// may insert wait states. While an access is outstanding the upstream stages
// are frozen through out_stall. Load data is lane-aligned and extended, then
// registered together with the write-back control for the WB stage.
// An access that sees no ack for TIMEOUT_CYCLES WAIT cycles is aborted.
//
// Configuration macro:
//   PIPE_MEM_SUBWORD_EN - when defined, byte/half accesses are supported.
//                         When undefined, every access is a full word.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_*                          EX/MEM slot (valid, rd control, ALU result,
//                                 store data, access type/size/signedness)
//   dmem_req/we/addr/wdata/be     data memory request (combinational)
//   dmem_rdata, dmem_ack          data memory response
//   out_stall                     freeze PC/IF/ID/EX and EX/MEM register
//   out_rd_*, out_alu_result,
//   out_dmem_data                 registered MEM/WB fields for pipe_wb
//   out_misalign, out_bus_err     1-cycle pulses for dropped/aborted accesses
// -----------------------------------------------------------------------------
module pipe_mem #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [4:0]  in_rd_waddr,
  input  logic        in_rd_wena,
  input  logic        in_rd_sel,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_store_data,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic [1:0]  in_mem_size,
  input  logic        in_mem_unsigned,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        out_stall,
  output logic [4:0]  out_rd_waddr,
  output logic        out_rd_wena,
  output logic        out_rd_sel,
  output logic [31:0] out_alu_result,
  output logic [31:0] out_dmem_data,
  output logic        out_misalign,
  output logic        out_bus_err
);

  localparam int unsigned    CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

`ifdef PIPE_MEM_SUBWORD_EN
  // Size 2'b11 is not a legal encoding; it is handled as a word everywhere.
  function automatic logic f_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   f_misaligned = 1'b0;
      2'b01:   f_misaligned = off[0];
      default: f_misaligned = (off != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] f_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   f_be = 4'b0001 << off;
      2'b01:   f_be = 4'b0011 << off;
      default: f_be = 4'hF;
    endcase
  endfunction

  // Byte/half are replicated so every lane carries the data; be picks the lane.
  function automatic logic [31:0] f_wdata(input logic [1:0] size, input logic [31:0] data);
    case (size)
      2'b00:   f_wdata = {4{data[7:0]}};
      2'b01:   f_wdata = {2{data[15:0]}};
      default: f_wdata = data;
    endcase
  endfunction

  function automatic logic [31:0] f_load(input logic [1:0] size, input logic uns,
                                         input logic [1:0] off, input logic [31:0] rdata);
    logic [31:0] lane;
    lane = rdata >> {off, 3'b000};
    case (size)
      2'b00:   f_load = uns ? {24'h000000, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      2'b01:   f_load = uns ? {16'h0000, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: f_load = rdata;
    endcase
  endfunction
`else
  // Word-only build: size and signedness play no part.
  function automatic logic f_misaligned(input logic [1:0] off);
    f_misaligned = (off != 2'b00);
  endfunction

  logic unused_s;
  assign unused_s = ^{in_mem_size, in_mem_unsigned};
`endif

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4:0]         rd_waddr_q, rd_waddr_d;
  logic               rd_wena_q, rd_wena_d;
  logic               rd_sel_q, rd_sel_d;
  logic [31:0]        alu_result_q, alu_result_d;
  logic [31:0]        dmem_data_q, dmem_data_d;
  logic               misalign_q, misalign_d;
  logic               bus_err_q, bus_err_d;

  logic               is_mem_s;
  logic               misaligned_s;
  logic               mem_op_s;
  logic               timeout_now_s;
  logic [31:0]        load_data_s;

  assign is_mem_s = in_valid & (in_mem_read | in_mem_write);

`ifdef PIPE_MEM_SUBWORD_EN
  assign misaligned_s = f_misaligned(in_mem_size, in_alu_result[1:0]);
  assign dmem_be      = f_be(in_mem_size, in_alu_result[1:0]);
  assign dmem_wdata   = f_wdata(in_mem_size, in_store_data);
  assign load_data_s  = f_load(in_mem_size, in_mem_unsigned, in_alu_result[1:0], dmem_rdata);
`else
  assign misaligned_s = f_misaligned(in_alu_result[1:0]);
  assign dmem_be      = 4'hF;
  assign dmem_wdata   = in_store_data;
  assign load_data_s  = dmem_rdata;
`endif

  assign mem_op_s  = is_mem_s & ~misaligned_s;
  assign dmem_we   = dmem_req & in_mem_write;
  assign dmem_addr = {in_alu_result[31:2], 2'b00};
  // Timeout cycle releases the stall so the aborted instruction retires as a bubble.
  assign out_stall = dmem_req & ~dmem_ack & ~timeout_now_s;

  // Handshake FSM: request generation, wait-state counting and timeout.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    dmem_req      = 1'b0;
    timeout_now_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        dmem_req = mem_op_s;
        if (mem_op_s && !dmem_ack) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          timeout_now_s = 1'b1;
          state_d       = ST_IDLE;
          cnt_d         = '0;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // MEM/WB register next value: bubble unless the instruction completes this cycle.
  always_comb begin
    rd_waddr_d   = 5'd0;
    rd_wena_d    = 1'b0;
    rd_sel_d     = 1'b0;
    alu_result_d = 32'h0000_0000;
    dmem_data_d  = 32'h0000_0000;
    misalign_d   = is_mem_s & misaligned_s & ~out_stall;
    bus_err_d    = timeout_now_s;
    if (out_stall || !in_valid || timeout_now_s || (is_mem_s && misaligned_s)) begin
      rd_waddr_d   = 5'd0;
      rd_wena_d    = 1'b0;
      rd_sel_d     = 1'b0;
      alu_result_d = 32'h0000_0000;
      dmem_data_d  = 32'h0000_0000;
    end else begin
      rd_waddr_d   = in_rd_waddr;
      rd_wena_d    = in_rd_wena;
      rd_sel_d     = in_rd_sel;
      alu_result_d = in_alu_result;
      dmem_data_d  = in_mem_read ? load_data_s : 32'h0000_0000;
    end
  end

  // State, counter and MEM/WB register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      rd_waddr_q   <= 5'd0;
      rd_wena_q    <= 1'b0;
      rd_sel_q     <= 1'b0;
      alu_result_q <= 32'h0000_0000;
      dmem_data_q  <= 32'h0000_0000;
      misalign_q   <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_waddr_q   <= rd_waddr_d;
      rd_wena_q    <= rd_wena_d;
      rd_sel_q     <= rd_sel_d;
      alu_result_q <= alu_result_d;
      dmem_data_q  <= dmem_data_d;
      misalign_q   <= misalign_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign out_rd_waddr   = rd_waddr_q;
  assign out_rd_wena    = rd_wena_q;
  assign out_rd_sel     = rd_sel_q;
  assign out_alu_result = alu_result_q;
  assign out_dmem_data  = dmem_data_q;
  assign out_misalign   = misalign_q;
  assign out_bus_err    = bus_err_q;

endmodule
